// File: rtl/lut_const_prog_pkg.sv
// Shared types and power-on defaults for the programmable constant lookup table.
package lut_const_prog_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } lut_state_e;

  // Power-on contents; callers truncate or zero-extend to their data width.
  function automatic logic [31:0] lut_default(input logic [31:0] idx);
    case (idx)
      32'd0:   return 32'd127;
      32'd1:   return 32'd1;
      32'd2:   return 32'd2;
      32'd3:   return 32'd128;
      32'd4:   return 32'd8;
      32'd5:   return 32'd3;
      32'd6:   return 32'd4;
      32'd7:   return 32'd5;
      32'd8:   return 32'd32;
      32'd9:   return 32'd6;
      32'd10:  return 32'd15;
      32'd11:  return 32'd64;
      32'd12:  return 32'd7;
      32'd13:  return 32'd255;
      32'd14:  return 32'd19;
      32'd15:  return 32'd20;
      default: return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/lut_const_prog_mem.sv
// Table storage: one synchronous write port, one combinational read port, no reset.
module lut_const_mem #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  localparam int DEPTH = 2**AW;

  logic [DW-1:0] mem_q [DEPTH];

  // Contents are rebuilt by the owner's INIT walk, so no reset here.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/lut_const_prog.sv
// Programmable constant LUT: INIT walk loads defaults, RUN serves pipelined
// lookups with write-first bypass and runtime writes.
module lut_const_prog
  import lut_const_prog_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW:0]   ptr,
  input  logic          rd_en,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          reload,
  output logic          ready,
  output logic [DW-1:0] constant,
  output logic          rd_valid,
  output logic          miss
);

  localparam logic [AW-1:0] LAST_IDX = {AW{1'b1}};

  lut_state_e    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          ready_q, ready_d;
  logic          rd_valid_q, rd_valid_d;
  logic          miss_q, miss_d;
  logic [DW-1:0] const_q, const_d;

  logic          run_s;
  logic          wr_take_s;
  logic          rd_take_s;
  logic          mem_we_s;
  logic [AW-1:0] mem_waddr_s;
  logic [DW-1:0] mem_wdata_s;
  logic [DW-1:0] mem_rdata_s;
  logic [DW-1:0] rd_word_s;

  assign run_s     = (state_q == ST_RUN);
  assign wr_take_s = run_s && wr_en && !reload;
  assign rd_take_s = run_s && rd_en;

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      idx_q      <= '0;
      ready_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      miss_q     <= 1'b0;
      const_q    <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ready_q    <= ready_d;
      rd_valid_q <= rd_valid_d;
      miss_q     <= miss_d;
      const_q    <= const_d;
    end
  end

  // Init walk sequencing; reload always restarts from index 0.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ready_d = ready_q;
    case (state_q)
      ST_INIT: begin
        if (reload) begin
          idx_d = '0;
        end else if (idx_q == LAST_IDX) begin
          state_d = ST_RUN;
          idx_d   = '0;
          ready_d = 1'b1;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      ST_RUN: begin
        if (reload) begin
          state_d = ST_INIT;
          idx_d   = '0;
          ready_d = 1'b0;
        end else begin
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_INIT;
        idx_d   = '0;
        ready_d = 1'b0;
      end
    endcase
  end

  // Write port mux: defaults during INIT, accepted runtime writes in RUN.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = wr_addr;
    mem_wdata_s = wr_data;
    if (state_q == ST_INIT) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = idx_q;
      mem_wdata_s = DW'(lut_default(32'(idx_q)));
    end else begin
      mem_we_s    = wr_take_s;
    end
  end

  lut_const_mem #(
    .DW (DW),
    .AW (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we_s),
    .waddr_i (mem_waddr_s),
    .wdata_i (mem_wdata_s),
    .raddr_i (ptr[AW-1:0]),
    .rdata_o (mem_rdata_s)
  );

  // Write-first: a same-cycle write to the read index wins over the stored word.
  always_comb begin
    rd_word_s = mem_rdata_s;
    if (wr_take_s && (wr_addr == ptr[AW-1:0])) begin
      rd_word_s = wr_data;
    end else begin
      rd_word_s = mem_rdata_s;
    end
  end

  // Lookup result stage; constant and miss hold when no read is accepted.
  always_comb begin
    rd_valid_d = 1'b0;
    miss_d     = miss_q;
    const_d    = const_q;
    if (rd_take_s) begin
      rd_valid_d = 1'b1;
      if (ptr[AW]) begin
        miss_d  = 1'b0;
        const_d = rd_word_s;
      end else begin
        miss_d  = 1'b1;
        const_d = '0;
      end
    end else begin
      rd_valid_d = 1'b0;
    end
  end

  assign ready    = ready_q;
  assign rd_valid = rd_valid_q;
  assign miss     = miss_q;
  assign constant = const_q;

endmodule

// File: doc/lut_const_prog.md
LUT_CONST_PROG -- requirements
Module: lut_const_prog

Interface
REQ-001 Parameter DW, default 8, constant data width in bits.
REQ-002 Parameter AW, default 4, table address width; DEPTH = 2**AW entries.
REQ-003 clk  input  1  single clock, all state rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 ptr  input  AW+1  lookup pointer; ptr[AW]=1 selects table, ptr[AW-1:0] is index.
REQ-006 rd_en  input  1  lookup request, sampled each cycle.
REQ-007 wr_en  input  1  runtime table write request.
REQ-008 wr_addr  input  AW  write index.
REQ-009 wr_data  input  DW  write value.
REQ-010 reload  input  1  pulse; restore all entries to defaults.
REQ-011 ready  output  1  high when table initialised and accepting reads/writes.
REQ-012 constant  output  DW  registered lookup result.
REQ-013 rd_valid  output  1  one-cycle pulse qualifying constant.
REQ-014 miss  output  1  qualifies rd_valid; high when ptr[AW]=0.

Function
REQ-015 FSM states SHALL be INIT and RUN; INIT walks index 0..DEPTH-1, writing one default per cycle.
REQ-016 INIT SHALL last exactly DEPTH cycles; transition INIT->RUN after writing index DEPTH-1; ready rises the cycle RUN is entered.
REQ-017 reload asserted in RUN SHALL enter INIT next cycle with index 0; reload in INIT restarts the walk at index 0.
REQ-018 In RUN, rd_en=1 SHALL produce rd_valid=1 exactly one cycle later, with constant = entry[ptr[AW-1:0]] and miss=0 when ptr[AW]=1.
REQ-019 In RUN, rd_en with ptr[AW]=0 SHALL produce rd_valid=1, miss=1, constant=0 one cycle later.
REQ-020 In RUN, wr_en=1 SHALL update entry[wr_addr] at the clock edge; wr_en in INIT is ignored.
REQ-021 Same-cycle read and write to the same index SHALL return wr_data (write-first bypass).
REQ-022 Same-cycle wr_en and reload SHALL give reload priority; the write is dropped.
REQ-023 rd_en in INIT SHALL be ignored: rd_valid=0, constant and miss hold.
REQ-024 When rd_valid=0, constant and miss SHALL hold previous values.
REQ-025 Reads and writes SHALL be fully pipelined: one new rd_en accepted per cycle, back-to-back.
REQ-026 Index counter SHALL wrap only by INIT->RUN transition; never exceeds DEPTH-1.

Reset
REQ-027 rst_n low SHALL force INIT, index 0, ready=0, rd_valid=0, miss=0, constant=0 asynchronously.
REQ-028 Table contents SHALL NOT be reset directly; they are rewritten by INIT after rst_n deasserts.
REQ-029 Reset mid-INIT or mid-RUN SHALL restart INIT from index 0; pending read results are discarded.

Structure
REQ-030 Shared package SHALL hold the state enum and default-value function: index 0..15 = 127,1,2,128,8,3,4,5,32,6,15,64,7,255,19,20 (truncated/zero-extended to DW); indices >=16 return 0.
REQ-031 Storage SHALL be one sub-module lut_const_mem (DEPTH x DW, one write port, one combinational read port); FSM, bypass and output registers live in lut_const_prog.

Verification
REQ-032 Reset release (defaults) -> ready=0 for 16 cycles, ready=1 on cycle 17; no rd_valid during INIT despite rd_en=1.
REQ-033 RUN, rd_en ptr=5'b10000, then 5'b11101 back-to-back -> constant 127 then 255 on consecutive rd_valid cycles, miss=0.
REQ-034 ptr=5'b00101 -> rd_valid=1, miss=1, constant=0.
REQ-035 wr_en addr=3 data=8'hAA with rd_en ptr=5'b10011 same cycle -> constant=8'hAA next cycle; later read also 8'hAA.
REQ-036 After REQ-035, reload pulse -> ready low 16 cycles; read ptr=5'b10011 -> 128.
REQ-037 rst_n low at INIT index 7 -> outputs zero immediately; full 16-cycle INIT after release, index 0 = 127.
